// File: rtl/divider_sequencer.sv
// ---------------------------------------------------------------------------
// divider_sequencer
//
// Run-time controller for the board clock divider. A divide ratio arrives on
// a valid/ready config port. The block produces a registered clock with a
// 50% duty cycle. It starts and stops that clock cleanly on period boundaries,
// and it can emit a counted burst of N periods before returning to idle.
//
// Ports
//   input_clk_i   system clock, all logic on the rising edge
//   input_rst_i   synchronous active-high reset
//   cfg_valid_i   config offer
//   cfg_ready_o   config accepted when cfg_valid_i && cfg_ready_o
//   cfg_half_i    cycles per output phase (0 is stored as 1)
//   cfg_count_i   periods per run (0 = free-run until stop)
//   start_i       one-cycle request to begin a run (idle only)
//   stop_i        one-cycle request to end a run at the next period boundary
//   output_clk_o  divided clock, registered
//   tick_o        one-cycle pulse in the cycle output_clk_o first reads 1
//   busy_o        high whenever the sequencer is not idle
//   done_o        one-cycle pulse in the cycle the sequencer returns to idle
// ---------------------------------------------------------------------------
module divider_sequencer #(
  parameter int unsigned WIDTH        = 25,
  parameter int unsigned CNT_W        = 16,
  parameter int unsigned DEFAULT_HALF = 25000000
) (
  input  logic             input_clk_i,
  input  logic             input_rst_i,
  input  logic             cfg_valid_i,
  output logic             cfg_ready_o,
  input  logic [WIDTH-1:0] cfg_half_i,
  input  logic [CNT_W-1:0] cfg_count_i,
  input  logic             start_i,
  input  logic             stop_i,
  output logic             output_clk_o,
  output logic             tick_o,
  output logic             busy_o,
  output logic             done_o
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_e;

  localparam logic [WIDTH-1:0] HalfOne     = WIDTH'(1);
  localparam logic [WIDTH-1:0] HalfDefault = WIDTH'(DEFAULT_HALF);
  localparam logic [CNT_W-1:0] CountOne    = CNT_W'(1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   half_q, half_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [CNT_W-1:0]   remaining_q, remaining_d;
  logic               shadowValid_q, shadowValid_d;
  logic [WIDTH-1:0]   shadowHalf_q, shadowHalf_d;
  logic [CNT_W-1:0]   shadowCount_q, shadowCount_d;
  logic               outClk_q, outClk_d;
  logic               tick_q, tick_d;
  logic               done_q, done_d;

  logic               cfgAccept;
  logic [WIDTH-1:0]   cfgHalfSan;
  logic               phaseEnd;
  logic               isFall;
  logic               burstEnd;
  logic               goIdle;

  // The shadow only ever fills while running, so readiness is simply
  // "shadow empty"; in idle the config goes straight to the live registers.
  assign cfg_ready_o = !shadowValid_q;
  assign cfgAccept   = cfg_valid_i && cfg_ready_o;

  // A zero half-period would never match the phase compare, so treat it as 1.
  assign cfgHalfSan  = (cfg_half_i == '0) ? HalfOne : cfg_half_i;

  // A fall is the phase-end toggle taken while the output is high; it closes
  // one full period and is the only point where the run may end or reconfigure.
  assign phaseEnd    = (cnt_q == half_q - HalfOne);
  assign isFall      = (state_q != IDLE) && phaseEnd && outClk_q;
  assign burstEnd    = (count_q != '0) && (remaining_q == CountOne);
  assign goIdle      = isFall && ((state_q == DRAIN) || stop_i || burstEnd);

  // Next-state and datapath logic. Everything holds by default; idle only
  // takes config and start, while RUN/DRAIN divide and act on falls.
  // A config accepted on the very fall that ends the run is committed
  // directly, otherwise it would be stranded in the shadow while idle.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    half_d        = half_q;
    count_d       = count_q;
    remaining_d   = remaining_q;
    shadowValid_d = shadowValid_q;
    shadowHalf_d  = shadowHalf_q;
    shadowCount_d = shadowCount_q;
    outClk_d      = outClk_q;
    tick_d        = 1'b0;
    done_d        = 1'b0;

    case (state_q)
      IDLE: begin
        if (cfgAccept) begin
          half_d  = cfgHalfSan;
          count_d = cfg_count_i;
        end
        if (start_i) begin
          state_d     = RUN;
          cnt_d       = '0;
          outClk_d    = 1'b0;
          remaining_d = cfgAccept ? cfg_count_i : count_q;
        end
      end

      RUN, DRAIN: begin
        cnt_d = cnt_q + HalfOne;
        if (cfgAccept) begin
          shadowValid_d = 1'b1;
          shadowHalf_d  = cfgHalfSan;
          shadowCount_d = cfg_count_i;
        end
        if (phaseEnd) begin
          cnt_d    = '0;
          outClk_d = !outClk_q;
          tick_d   = !outClk_q;
        end
        if (isFall) begin
          if (count_q != '0) begin
            remaining_d = remaining_q - CountOne;
          end
          if (shadowValid_q) begin
            half_d        = shadowHalf_q;
            count_d       = shadowCount_q;
            shadowValid_d = 1'b0;
          end else if (cfgAccept && goIdle) begin
            half_d        = cfgHalfSan;
            count_d       = cfg_count_i;
            shadowValid_d = 1'b0;
          end
          if (goIdle) begin
            state_d  = IDLE;
            outClk_d = 1'b0;
            done_d   = 1'b1;
          end
        end else if ((state_q == RUN) && stop_i) begin
          state_d = DRAIN;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State register with synchronous reset; reset discards any pending
  // shadow config and deliberately produces no done pulse.
  always_ff @(posedge input_clk_i) begin
    if (input_rst_i) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      half_q        <= HalfDefault;
      count_q       <= '0;
      remaining_q   <= '0;
      shadowValid_q <= 1'b0;
      shadowHalf_q  <= '0;
      shadowCount_q <= '0;
      outClk_q      <= 1'b0;
      tick_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      half_q        <= half_d;
      count_q       <= count_d;
      remaining_q   <= remaining_d;
      shadowValid_q <= shadowValid_d;
      shadowHalf_q  <= shadowHalf_d;
      shadowCount_q <= shadowCount_d;
      outClk_q      <= outClk_d;
      tick_q        <= tick_d;
      done_q        <= done_d;
    end
  end

  assign output_clk_o = outClk_q;
  assign tick_o       = tick_q;
  assign done_o       = done_q;
  assign busy_o       = (state_q != IDLE);

endmodule

// File: tb/tb_divider_sequencer.sv
// ---------------------------------------------------------------------------
// tb_divider_sequencer
//
// Self-checking bench for divider_sequencer. DEFAULT_HALF is shrunk to 7 so
// the post-reset ratio can be observed in a few cycles. A table of whole-run
// waveforms covers the plain divide and burst cases. Hand-written sequences
// cover stop timing, shadow reconfiguration, reset mid-run and the
// burst-end/shadow collision.
// Sample index 0 is the cycle right after the start edge. Outputs are
// sampled 1 time unit after each rising edge.
// ---------------------------------------------------------------------------
module tb_divider_sequencer;

  logic        clk;
  logic        rst;
  logic        cfgValid;
  logic        cfgReady;
  logic [24:0] cfgHalf;
  logic [15:0] cfgCount;
  logic        start;
  logic        stop;
  logic        outClk;
  logic        tick;
  logic        busy;
  logic        done;

  int checks;
  int failures;

  divider_sequencer #(
    .WIDTH(25),
    .CNT_W(16),
    .DEFAULT_HALF(7)
  ) dut (
    .input_clk_i (clk),
    .input_rst_i (rst),
    .cfg_valid_i (cfgValid),
    .cfg_ready_o (cfgReady),
    .cfg_half_i  (cfgHalf),
    .cfg_count_i (cfgCount),
    .start_i     (start),
    .stop_i      (stop),
    .output_clk_o(outClk),
    .tick_o      (tick),
    .busy_o      (busy),
    .done_o      (done)
  );

  // Free-running 10-unit clock
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Hard stop in case something wedges the main sequence
  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Waveform record: bit (len-1-i) of each pattern is the value at sample i
  typedef struct {
    int          half;
    int          count;
    bit          sameCycle;
    int          len;
    logic [31:0] expClk;
    logic [31:0] expTick;
    logic [31:0] expBusy;
    logic [31:0] expDone;
  } vec_t;

  vec_t vecs[4];

  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input bit v, input int h, input int c,
                               input bit s, input bit p, input bit r);
    cfgValid = v;
    cfgHalf  = h[24:0];
    cfgCount = c[15:0];
    start    = s;
    stop     = p;
    rst      = r;
  endtask

  task automatic idleInputs();
    applyStimulus(1'b0, 0, 0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic checkOutput(input string tag, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d", tag, actual, expected);
    end
  endtask

  task automatic checkAll(input string tag, input int c, input int t,
                          input int b, input int d, input int r);
    checkOutput({tag, " clk"},   int'(outClk),   c);
    checkOutput({tag, " tick"},  int'(tick),     t);
    checkOutput({tag, " busy"},  int'(busy),     b);
    checkOutput({tag, " done"},  int'(done),     d);
    checkOutput({tag, " ready"}, int'(cfgReady), r);
  endtask

  task automatic doReset();
    applyStimulus(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
    stepCycle();
    idleInputs();
  endtask

  // Accept a config in idle, then start on the following cycle
  task automatic cfgThenStart(input int h, input int c);
    applyStimulus(1'b1, h, c, 1'b0, 1'b0, 1'b0);
    stepCycle();
    applyStimulus(1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
    stepCycle();
    idleInputs();
  endtask

  // Start with no new config; the ratio must be the reset default of 7
  task automatic checkDefaultRun(input string tag);
    int highs;
    highs = 0;
    applyStimulus(1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
    stepCycle();
    idleInputs();
    for (int i = 0; i < 7; i++) begin
      highs += int'(outClk);
      stepCycle();
    end
    checkOutput({tag, " lowPhaseHighs"}, highs, 0);
    checkOutput({tag, " firstRise clk"}, int'(outClk), 1);
    checkOutput({tag, " firstRise tick"}, int'(tick), 1);
  endtask

  initial begin
    int doneCount;
    int highs;

    checks   = 0;
    failures = 0;
    idleInputs();

    // Whole-run waveforms, hand-derived from the phase counting rules
    vecs[0] = '{half: 3, count: 0, sameCycle: 1'b0, len: 18,
                expClk:  32'(18'b000111000111000111),
                expTick: 32'(18'b000100000100000100),
                expBusy: 32'(18'b111111111111111111),
                expDone: 32'(18'b000000000000000000)};
    vecs[1] = '{half: 2, count: 4, sameCycle: 1'b0, len: 20,
                expClk:  32'(20'b00110011001100110000),
                expTick: 32'(20'b00100010001000100000),
                expBusy: 32'(20'b11111111111111110000),
                expDone: 32'(20'b00000000000000001000)};
    vecs[2] = '{half: 0, count: 3, sameCycle: 1'b1, len: 10,
                expClk:  32'(10'b0101010000),
                expTick: 32'(10'b0101010000),
                expBusy: 32'(10'b1111110000),
                expDone: 32'(10'b0000001000)};
    vecs[3] = '{half: 4, count: 1, sameCycle: 1'b1, len: 10,
                expClk:  32'(10'b0000111100),
                expTick: 32'(10'b0000100000),
                expBusy: 32'(10'b1111111100),
                expDone: 32'(10'b0000000010)};

    // Reset followed by ten quiet idle cycles
    doReset();
    checkAll("reset", 0, 0, 0, 0, 1);
    for (int i = 0; i < 10; i++) begin
      stepCycle();
      checkAll($sformatf("idle[%0d]", i), 0, 0, 0, 0, 1);
    end

    // Table-driven runs
    for (int v = 0; v < 4; v++) begin
      doReset();
      if (vecs[v].sameCycle) begin
        applyStimulus(1'b1, vecs[v].half, vecs[v].count, 1'b1, 1'b0, 1'b0);
        stepCycle();
        idleInputs();
      end else begin
        cfgThenStart(vecs[v].half, vecs[v].count);
      end
      for (int i = 0; i < vecs[v].len; i++) begin
        int b;
        b = vecs[v].len - 1 - i;
        checkAll($sformatf("vec%0d[%0d]", v, i),
                 int'(vecs[v].expClk[b]), int'(vecs[v].expTick[b]),
                 int'(vecs[v].expBusy[b]), int'(vecs[v].expDone[b]), 1);
        stepCycle();
      end
    end

    // Stop in the high phase: the period completes and done pulses once
    doReset();
    cfgThenStart(5, 0);
    repeat (6) stepCycle();
    checkOutput("stopHigh s6 clk", int'(outClk), 1);
    applyStimulus(1'b0, 0, 0, 1'b0, 1'b1, 1'b0);
    stepCycle();
    idleInputs();
    checkAll("stopHigh s7", 1, 0, 1, 0, 1);
    doneCount = 0;
    for (int i = 8; i <= 14; i++) begin
      stepCycle();
      doneCount += int'(done);
      if (i == 9)  checkAll("stopHigh s9", 1, 0, 1, 0, 1);
      if (i == 10) checkAll("stopHigh s10", 0, 0, 0, 1, 1);
    end
    checkOutput("stopHigh doneCount", doneCount, 1);

    // Stop landing exactly on a fall: idle that edge, no extra period
    doReset();
    cfgThenStart(5, 0);
    repeat (9) stepCycle();
    checkOutput("stopFall s9 clk", int'(outClk), 1);
    applyStimulus(1'b0, 0, 0, 1'b0, 1'b1, 1'b0);
    stepCycle();
    idleInputs();
    checkAll("stopFall s10", 0, 0, 0, 1, 1);
    highs = 0;
    for (int i = 0; i < 12; i++) begin
      stepCycle();
      highs += int'(outClk) + int'(busy) + int'(done);
    end
    checkOutput("stopFall quietAfter", highs, 0);

    // Reconfigure while running: ready drops until the next fall
    doReset();
    cfgThenStart(3, 0);
    stepCycle();
    applyStimulus(1'b1, 1, 0, 1'b0, 1'b0, 1'b0);
    stepCycle();
    idleInputs();
    checkAll("shadow s2", 0, 0, 1, 0, 0);
    stepCycle();
    checkAll("shadow s3", 1, 1, 1, 0, 0);
    stepCycle();
    stepCycle();
    checkAll("shadow s5", 1, 0, 1, 0, 0);
    stepCycle();
    checkAll("shadow s6", 0, 0, 1, 0, 1);
    stepCycle();
    checkAll("shadow s7", 1, 1, 1, 0, 1);
    stepCycle();
    checkAll("shadow s8", 0, 0, 1, 0, 1);
    stepCycle();
    checkAll("shadow s9", 1, 1, 1, 0, 1);

    // Reset during RUN
    doReset();
    cfgThenStart(3, 0);
    repeat (4) stepCycle();
    checkOutput("rstRun s4 clk", int'(outClk), 1);
    applyStimulus(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
    stepCycle();
    idleInputs();
    checkAll("rstRun after", 0, 0, 0, 0, 1);
    checkDefaultRun("rstRun restart");

    // Reset during DRAIN with a pending shadow config
    doReset();
    cfgThenStart(4, 0);
    repeat (5) stepCycle();
    applyStimulus(1'b0, 0, 0, 1'b0, 1'b1, 1'b0);
    stepCycle();
    checkAll("rstDrain s6", 1, 0, 1, 0, 1);
    applyStimulus(1'b1, 2, 0, 1'b0, 1'b0, 1'b0);
    stepCycle();
    idleInputs();
    checkAll("rstDrain s7", 1, 0, 1, 0, 0);
    applyStimulus(1'b0, 0, 0, 1'b0, 1'b0, 1'b1);
    stepCycle();
    idleInputs();
    checkAll("rstDrain after", 0, 0, 0, 0, 1);
    checkDefaultRun("rstDrain restart");

    // Burst end and shadow apply on the same fall: the shadow governs the next run
    doReset();
    cfgThenStart(2, 1);
    applyStimulus(1'b1, 3, 2, 1'b0, 1'b0, 1'b0);
    stepCycle();
    idleInputs();
    checkAll("burstShadow s1", 0, 0, 1, 0, 0);
    repeat (3) stepCycle();
    checkAll("burstShadow s4", 0, 0, 0, 1, 1);
    applyStimulus(1'b0, 0, 0, 1'b1, 1'b0, 1'b0);
    stepCycle();
    idleInputs();
    for (int i = 1; i <= 13; i++) begin
      stepCycle();
      if (i == 2)  checkOutput("burstShadow next s2 clk", int'(outClk), 0);
      if (i == 3)  checkAll("burstShadow next s3", 1, 1, 1, 0, 1);
      if (i == 11) checkAll("burstShadow next s11", 1, 0, 1, 0, 1);
      if (i == 12) checkAll("burstShadow next s12", 0, 0, 0, 1, 1);
      if (i == 13) checkAll("burstShadow next s13", 0, 0, 0, 0, 1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
